// File: rtl/shader_dispatch.sv
// Per-pixel read -> shade -> write dispatcher for one framebuffer job.
// Optional WAIT_SH watchdog: define SHADER_DISPATCH_WATCHDOG_EN.
module shader_dispatch #(
    parameter int ADDR_W      = 16,
    parameter int PIX_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    output logic              busy,
    output logic              frame_done,
    output logic              err,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] num_px,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              sh_start,
    output logic [PIX_W-1:0]  sh_pixel,
    input  logic [PIX_W-1:0]  sh_result,
    input  logic              sh_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        ISSUE,
        WAIT_SH,
        WRITE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [PIX_W-1:0]  res_q, res_d;

    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              sh_start_d;
    logic [PIX_W-1:0]  sh_pixel_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [PIX_W-1:0]  wr_data_d;
    logic              frame_done_d;
    logic              busy_d;

`ifdef SHADER_DISPATCH_WATCHDOG_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    logic       timeout;

    assign timeout = (wdog_q == TO_LAST);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        res_d   = res_q;
`ifdef SHADER_DISPATCH_WATCHDOG_EN
        err_d   = err_q;
        wdog_d  = (state_q == WAIT_SH) ? wdog_q + 8'd1 : 8'd0;
`endif

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    cnt_d   = num_px;
                    idx_d   = '0;
                    state_d = (num_px == '0) ? DONE : READ;
                end
            end
            READ: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                pix_d   = rd_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_SH;
            end
            WAIT_SH: begin
                if (sh_done) begin
                    res_d   = sh_result;
                    state_d = WRITE;
                end
`ifdef SHADER_DISPATCH_WATCHDOG_EN
                else if (timeout) begin
                    // Stalled shader: pass the pixel through untouched
                    res_d   = pix_q;
                    err_d   = 1'b1;
                    state_d = WRITE;
                end
`endif
            end
            WRITE: begin
                if (idx_q == cnt_q - ADDR_W'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
`ifdef SHADER_DISPATCH_WATCHDOG_EN
            err_d   = err_q;
`endif
        end

        // Outputs are registered from the next state so strobes line up
        rd_en_d      = (state_d == READ);
        rd_addr_d    = rd_en_d ? src_d + idx_d : rd_addr;
        sh_start_d   = (state_d == ISSUE);
        sh_pixel_d   = sh_start_d ? pix_d : sh_pixel;
        wr_en_d      = (state_d == WRITE);
        wr_addr_d    = wr_en_d ? dst_d + idx_d : wr_addr;
        wr_data_d    = wr_en_d ? res_d : wr_data;
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            pix_q      <= '0;
            res_q      <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            sh_start   <= 1'b0;
            sh_pixel   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pix_q      <= pix_d;
            res_q      <= res_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            sh_start   <= sh_start_d;
            sh_pixel   <= sh_pixel_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
        end
    end

`ifdef SHADER_DISPATCH_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`endif

endmodule
